// File: rtl/crg_rst_cen_if.sv
// crg_rst_cen_if: ratio programming, enable gates and reset/enable outputs of crg_rst_cen
interface crg_rst_cen_if #(
    parameter int NCH = 4,
    parameter int W   = 16
);
    logic [NCH*W-1:0] num;
    logic [NCH*W-1:0] den;
    logic [NCH-1:0]   ch_en;
    logic [NCH-1:0]   rst_out;
    logic [NCH-1:0]   cen;
    logic             ready;

    modport master (output num, den, ch_en, input rst_out, cen, ready);
    modport slave  (input num, den, ch_en, output rst_out, cen, ready);
endinterface

// File: rtl/crg_rst_cen.sv
// crg_rst_cen: PLL-lock debounced, staggered per-channel reset release plus
// num/den fractional clock-enable generators, all in the PLL output clock domain.
module crg_rst_cen #(
    parameter int NCH     = 4,
    parameter int W       = 16,
    parameter int STRETCH = 1024,
    parameter int STAGGER = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    crg_rst_cen_if.slave bus
);
    localparam int CW = $clog2(STRETCH > STAGGER ? STRETCH : STAGGER) + 1;
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} state_t;

    state_t           state;
    logic [1:0]       sync;
    logic             lock_s;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    nxt;
    logic [NCH-1:0]   rst_q;
    logic [NCH-1:0]   cen_q;
    logic             ready_q;

    assign lock_s      = sync[1];
    assign nxt         = idx + 1'b1;
    assign bus.rst_out = rst_q;
    assign bus.cen     = cen_q;
    assign bus.ready   = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], pll_locked};
    end

    // STABLE exits one count early so that channel 0 releases exactly STRETCH
    // cycles after lock_s rises (one cycle is spent leaving WAIT_LOCK).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            idx     <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else if (!lock_s) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            idx     <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
                STABLE: begin
                    if (cnt == CW'(STRETCH - 2)) begin
                        rst_q[0] <= 1'b0;
                        idx      <= '0;
                        cnt      <= '0;
                        state    <= NCH == 1 ? RUN : RELEASE;
                    end else cnt <= cnt + 1'b1;
                end
                RELEASE: begin
                    if (cnt == CW'(STAGGER - 1)) begin
                        cnt        <= '0;
                        idx        <= nxt;
                        rst_q[nxt] <= 1'b0;
                        if (idx == IW'(NCH - 2)) state <= RUN;
                    end else cnt <= cnt + 1'b1;
                end
                RUN: ready_q <= 1'b1;
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [W-1:0] n;
        logic [W-1:0] d;
        logic [W:0]   acc;
        logic [W:0]   s;
        logic         act;
        logic         c;
        assign n        = bus.num[i*W +: W];
        assign d        = bus.den[i*W +: W];
        assign s        = acc + {1'b0, n};
        assign act      = !rst_q[i] && bus.ch_en[i] && |n && |d;
        assign cen_q[i] = c;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
                c   <= 1'b0;
            end else if (!lock_s) begin
                acc <= '0;
                c   <= 1'b0;
            end else if (!act) begin
                c <= 1'b0;
            end else if (n >= d) begin
                acc <= '0;
                c   <= 1'b1;
            end else begin
                c   <= s >= {1'b0, d};
                acc <= s >= {1'b0, d} ? s - {1'b0, d} : s;
            end
        end
    end
endmodule

// File: tb/tb_crg_rst_cen.sv
// tb_crg_rst_cen: directed sequencing/ratio vectors, checked every cycle against a
// time-since-lock reset model and a per-channel ratio model, plus literal expectations.
module tb_crg_rst_cen;
    localparam int NCH = 4, W = 16, STRETCH = 8, STAGGER = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic pll_locked;
    int   vecs = 0, errs = 0;
    logic chk_on = 1'b0;

    crg_rst_cen_if #(.NCH(NCH), .W(W)) bus ();
    crg_rst_cen #(.NCH(NCH), .W(W), .STRETCH(STRETCH), .STAGGER(STAGGER)) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int i, input int n, input int d);
        bus.num[i*W +: W] = W'(n);
        bus.den[i*W +: W] = W'(d);
    endtask

    // Model: reset outputs follow from the number of consecutive locked cycles k;
    // each enable channel follows the num/den accumulate-and-subtract rule.
    int             k;
    logic           m_s1, m_s2;
    logic [NCH-1:0] m_rst, m_cen;
    logic           m_ready;
    int             acc[NCH];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = 0; m_s2 = 0; k = 0; m_rst = '1; m_cen = '0; m_ready = 0;
                for (int i = 0; i < NCH; i++) acc[i] = 0;
            end else begin
                logic lk;
                lk = m_s2; m_s2 = m_s1; m_s1 = pll_locked;
                if (!lk) begin
                    k = 0; m_cen = '0;
                    for (int i = 0; i < NCH; i++) acc[i] = 0;
                end else begin
                    k++;
                    for (int i = 0; i < NCH; i++) begin
                        int n, d, s;
                        n = int'(bus.num[i*W +: W]);
                        d = int'(bus.den[i*W +: W]);
                        m_cen[i] = 1'b0;
                        if (!m_rst[i] && bus.ch_en[i] && n != 0 && d != 0) begin
                            if (n >= d) begin m_cen[i] = 1'b1; acc[i] = 0; end
                            else begin
                                s = acc[i] + n;
                                m_cen[i] = s >= d;
                                acc[i] = s >= d ? s - d : s;
                            end
                        end
                    end
                end
                for (int i = 0; i < NCH; i++) m_rst[i] = !(k >= STRETCH + i*STAGGER);
                m_ready = k >= STRETCH + (NCH-1)*STAGGER + 1;
            end
        end
    end

    always @(negedge clk)
        if (chk_on && rst_n)
            chk("cycle{rst_out,cen,ready}", {23'd0, bus.rst_out, bus.cen, bus.ready},
                {23'd0, m_rst, m_cen, m_ready});

    int f[NCH];
    int rdy, c0, first0, c1, c2, c3, adj, win_end;

    task automatic seq(input int len);
        logic prev = 1'b0;
        for (int i = 0; i < NCH; i++) f[i] = 0;
        rdy = 0; c0 = 0; first0 = 0; c1 = 0; c2 = 0; c3 = 0; adj = 0;
        for (int n = 1; n <= len; n++) begin
            @(negedge clk);
            chk_on = 1'b1;
            for (int i = 0; i < NCH; i++) if (f[i] == 0 && !bus.rst_out[i]) f[i] = n;
            if (rdy == 0 && bus.ready) rdy = n;
            if (bus.cen[0]) begin
                if (first0 == 0) first0 = n;
                if (n >= 11 && n <= win_end) c0++;
                if (prev) adj++;
            end
            prev = bus.cen[0];
            if (bus.cen[1] && n >= 15) c1++;
            if (bus.cen[2]) c2++;
            if (bus.cen[3]) c3++;
        end
    endtask

    task automatic chk_release(input string tag);
        for (int i = 0; i < NCH; i++)
            chk($sformatf("%s_fall%0d", tag, i), f[i], 10 + i*STAGGER);
        chk({tag, "_ready"}, rdy, 23);
        chk({tag, "_first_cen0"}, first0, 13);
    endtask

    initial begin
        int p;
        rst_n = 1'b0; pll_locked = 1'b1;
        bus.num = '0; bus.den = '0; bus.ch_en = '1;
        set_ch(0, 26, 53); set_ch(1, 7, 7); set_ch(2, 0, 5); set_ch(3, 5, 0);
        repeat (3) @(negedge clk);
        chk("reset_rst_out", bus.rst_out, 4'hF);
        chk("reset_cen", bus.cen, 4'h0);
        chk("reset_ready", bus.ready, 1'b0);

        rst_n = 1'b1;
        win_end = 5310;
        seq(5310);
        chk_release("boot");
        chk("frac_26_53", c0, 2600);
        chk("adjacent_cen0", adj, 0);
        chk("num_eq_den", c1, 5296);
        chk("num_zero", c2, 0);
        chk("den_zero", c3, 0);

        set_ch(1, 9, 4);
        p = 0;
        repeat (20) begin @(negedge clk); if (bus.cen[1]) p++; end
        chk("num_gt_den", p, 20);

        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        chk("loss_rst_out", bus.rst_out, 4'hF);
        chk("loss_cen", bus.cen, 4'h0);
        chk("loss_ready", bus.ready, 1'b0);
        pll_locked = 1'b1;
        win_end = 540;
        seq(600);
        chk_release("relock");
        chk("relock_frac", c0, 260);

        pll_locked = 1'b0;
        repeat (5) @(negedge clk);
        set_ch(0, 1, 2);
        pll_locked = 1'b1;
        repeat (6) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        chk("glitch_held", bus.rst_out, 4'hF);
        pll_locked = 1'b1;
        seq(40);
        for (int i = 0; i < NCH; i++) chk($sformatf("glitch_fall%0d", i), f[i], 10 + i*STAGGER);
        chk("glitch_ready", rdy, 23);

        p = 0;
        for (int i = 0; i < 400; i++) begin
            logic en;
            en = (i % 2) == 0;
            bus.ch_en[0] = en;
            @(negedge clk);
            if (bus.cen[0]) begin
                p++;
                if (!en) chk("gated_pulse", 1, 0);
            end
        end
        chk("gated_count", p, 100);
        bus.ch_en[0] = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/crg_rst_cen.md
Name: crg_rst_cen

Overview:
- Parametrised successor to the board clock/reset generator: sits directly after the board PLL, in the PLL output clock domain.
- Sequences per-domain reset release from the PLL lock flag: debounce, then staggered release.
- Generates NCH fractional clock-enable channels (num/den ratios such as 26/53 audio, 1/2 half-rate) so cores use clock enables instead of extra PLL outputs.
- Replaces fixed PLL divider outputs with run-time programmable ratios.

Parameters:
- NCH, 4, number of reset/clock-enable channels (1..8)
- W, 16, width of num/den per channel
- STRETCH, 1024, consecutive locked cycles required before release starts (≥2)
- STAGGER, 16, cycles between successive channel reset releases (≥1)

Ports:
- clk  in  1  PLL output clock; sole clock
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock flag, asynchronous to clk; synchronised internally by 2 flops
- num  in  NCH*W  per-channel numerator; channel i at [i*W +: W]
- den  in  NCH*W  per-channel denominator; same packing
- ch_en  in  NCH  per-channel clock-enable gate
- rst_out  out  NCH  per-channel active-high synchronous reset
- cen  out  NCH  per-channel one-cycle clock-enable pulses
- ready  out  1  high when all channels are released

Behaviour:
- Reset (rst_n=0, asynchronous): rst_out = all ones, cen = 0, ready = 0, state = WAIT_LOCK, all counters and accumulators = 0.
- lock_s: pll_locked after a 2-flop synchroniser (sync flops also reset to 0).
- FSM:
  - WAIT_LOCK: if lock_s=1, go to STABLE with cnt=0.
  - STABLE: cnt increments each cycle. When cnt reaches STRETCH-1 with lock_s still 1, go to RELEASE with idx=0, cnt=0.
  - RELEASE: rst_out[idx] clears on RELEASE entry. Afterwards, every STAGGER cycles idx increments and rst_out[idx] clears. After rst_out[NCH-1] clears, go to RUN.
  - RUN: ready=1 (registered; first high the cycle after rst_out[NCH-1] clears). Hold.
- Lock loss: lock_s=0 in any state other than WAIT_LOCK →
  - next cycle: rst_out = all ones, ready = 0, cen = 0, all accumulators cleared;
  - state → WAIT_LOCK.
  - A lock glitch during STABLE therefore restarts the full STRETCH count.
- Release order: channel 0 first, NCH-1 last.
- Release timing: rst_out[i] falls exactly STRETCH + i*STAGGER cycles after lock_s first rises.
- Fractional enable, channel i:
  - Accumulator acc is W+1 bits. Channel is active when rst_out[i]=0 and ch_en[i]=1.
  - Each active cycle: s = acc + num. If s ≥ den, then cen[i]=1 next cycle and acc ← s − den; else cen[i]=0 and acc ← s.
  - Arithmetic is unsigned in W+1 bits; no overflow because acc < den ≤ 2^W−1.
  - Inactive channel: cen[i]=0 and acc holds its value. acc is cleared only by reset or lock loss.
- Ratio guarantees:
  - Over any den consecutive active cycles: exactly num pulses for 0 < num < den.
  - num ≥ den: cen every active cycle, acc forced to 0.
  - num = 0 or den = 0: cen never asserted; den = 0 is treated as channel disabled.
- Output timing: cen is registered and one clk wide. First pulse can appear no earlier than the cycle after the channel goes active.
- num/den changes apply from the next cycle's computation. No re-synchronisation or clearing occurs.
- Simultaneous lock loss and release step: lock loss wins.
- rst_out, cen and ready are all flop outputs (glitch-free).

Test Plan:
- Reset state: rst_n=0 with pll_locked=1 → rst_out=4'hF, cen=0, ready=0. rst_n=1, STRETCH=8, STAGGER=4 → rst_out[0..3] fall at 8/12/16/20 cycles after lock_s rises; ready=1 at cycle 21.
- Lock glitch: pll_locked low for 1 cycle at STRETCH count 5 → nothing released. Release occurs 8 cycles after the second lock_s rise.
- Fraction 26/53 on channel 0, ch_en=1, 5300 active cycles → exactly 2600 cen pulses; no two pulses adjacent.
- Boundary ratios:
  - ch1 num=den=7 → cen high every cycle after release;
  - ch2 num=0 → no pulses;
  - ch3 den=0 → no pulses;
  - ch1 num=9, den=4 → continuous cen.
- Lock loss in RUN: pll_locked→0 → within 3 clk cycles rst_out=all ones, ready=0, cen=0. Relock → full sequence repeats and the 26/53 count restarts from acc=0.
- ch_en gating: toggle ch_en[0] at 50% duty during 1/2 ratio over 400 cycles → 100 pulses; pulses occur only while ch_en is high.
